instr_fetch: RTL and testbench

Program-counter and fetch/decode stage directly upstream of the execute datapath and directly driving the 16-entry program ROM. It holds the PC, reads one 16-bit instruction per fetch from the asynchronous ROM, splits it into fields and presents it to the execute stage over a valid/ready handshake. It resolves unconditional jumps locally and stalls on conditional branches until execute reports the outcome.

---
 rtl/instr_fetch_pkg.sv | 19 +
 rtl/instr_fetch_field_decode.sv | 17 +
 rtl/instr_fetch.sv | 74 +++++++
 tb/tb_instr_fetch.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// instr_fetch_pkg: shared widths, opcodes, instruction field positions and fetch FSM states
package instr_fetch_pkg;
    localparam int ADDR_W = 4;
    localparam int INST_W = 16;
    localparam logic [3:0] OP_LOAD = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_JMP  = 4'b1000;
    localparam logic [3:0] OP_SUBI = 4'b1011;
    localparam logic [3:0] OP_BR   = 4'b1100;
    localparam logic [3:0] OP_MOV  = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;
    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS_LSB  = 6;
    localparam int IMM_LSB = 0;
    localparam int TGT_LSB = 8;
    typedef enum logic [1:0] {FETCH, ISSUE, WAIT_BR} state_t;
endpackage

// File: rtl/instr_fetch_field_decode.sv
// instr_field_decode: combinational split of an instruction word into its fields
module instr_field_decode
    import instr_fetch_pkg::*;
(
    input  logic [INST_W-1:0] inst,
    output logic [3:0]        opcode,
    output logic [2:0]        rd,
    output logic [2:0]        rs,
    output logic [7:0]        imm,
    output logic [ADDR_W-1:0] target
);
    assign opcode = inst[OPC_LSB +: 4];
    assign rd     = inst[RD_LSB +: 3];
    assign rs     = inst[RS_LSB +: 3];
    assign imm    = inst[IMM_LSB +: 8];
    assign target = inst[TGT_LSB +: ADDR_W];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC + fetch/issue stage with branch stall; INSTR_FETCH_JMP_FOLD_EN folds JMP during fetch
module instr_fetch
    import instr_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [3:0]        out_opcode,
    output logic [2:0]        out_rd,
    output logic [2:0]        out_rs,
    output logic [7:0]        out_imm,
    output logic [ADDR_W-1:0] out_target,
    output logic [ADDR_W-1:0] out_pc,
    input  logic              br_resolve_valid,
    input  logic              br_taken
);
`ifdef INSTR_FETCH_JMP_FOLD_EN
    localparam bit JMP_FOLD = 1'b1;
`else
    localparam bit JMP_FOLD = 1'b0;
`endif
    state_t state, state_nx;
    logic [ADDR_W-1:0] pc, pc_nx;
    logic [INST_W-1:0] ir;
    logic fold;
    assign fold      = JMP_FOLD && rom_inst[OPC_LSB +: 4] == OP_JMP;
    assign rom_addr  = pc;
    assign out_valid = state == ISSUE;
    instr_field_decode u_dec (
        .inst   (ir),
        .opcode (out_opcode),
        .rd     (out_rd),
        .rs     (out_rs),
        .imm    (out_imm),
        .target (out_target)
    );
    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        unique case (state)
            FETCH: begin
                state_nx = fold ? FETCH : ISSUE;
                pc_nx    = fold ? rom_inst[TGT_LSB +: ADDR_W] : pc + 1'b1;
            end
            ISSUE: if (out_ready) begin
                state_nx = out_opcode == OP_BR ? WAIT_BR : FETCH;
                pc_nx    = (!JMP_FOLD && out_opcode == OP_JMP) ? out_target : pc;
            end
            WAIT_BR: if (br_resolve_valid) begin
                state_nx = FETCH;
                pc_nx    = br_taken ? out_target : pc;
            end
            default: state_nx = FETCH;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= FETCH;
            pc     <= '0;
            ir     <= '0;
            out_pc <= '0;
        end else begin
            state <= state_nx;
            pc    <= pc_nx;
            if (state == FETCH && !fold) begin
                ir     <= rom_inst;
                out_pc <= pc;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed program run against a transaction-level model of the fetch stage
module tb_instr_fetch;
    logic        clk = 0;
    logic        rst = 1;
    logic [3:0]  rom_addr;
    logic [15:0] rom_inst;
    logic        out_valid;
    logic        out_ready = 0;
    logic [3:0]  out_opcode;
    logic [2:0]  out_rd, out_rs;
    logic [7:0]  out_imm;
    logic [3:0]  out_target, out_pc;
    logic        br_resolve_valid = 0;
    logic        br_taken = 0;
    logic [15:0] rom [16];
    int pass_cnt = 0;
    int total = 0;

    instr_fetch dut (
        .clk(clk), .rst(rst), .rom_addr(rom_addr), .rom_inst(rom_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
        .out_rd(out_rd), .out_rs(out_rs), .out_imm(out_imm), .out_target(out_target),
        .out_pc(out_pc), .br_resolve_valid(br_resolve_valid), .br_taken(br_taken)
    );

    assign rom_inst = rom[rom_addr];
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Follow JMP chains the way a folding fetch would never let them reach issue
    function automatic logic [3:0] skip(input logic [3:0] a);
        logic [3:0] p;
        p = a;
`ifdef INSTR_FETCH_JMP_FOLD_EN
        for (int i = 0; i < 16; i++) if (rom[p][15:12] == 4'h8) p = rom[p][11:8];
`endif
        return p;
    endfunction

    logic [3:0] exp_pc = 0, br_tgt = 0, br_next = 0;
    bit pending = 0;
    always @(negedge clk) begin
        logic [15:0] w;
        w = rom[exp_pc];
        if (rst) begin
            exp_pc  = skip(4'd0);
            pending = 0;
        end else if (pending) begin
            check("m_wait_valid", out_valid, 0);
            if (br_resolve_valid) begin
                exp_pc  = skip(br_taken ? br_tgt : br_next);
                pending = 0;
            end
        end else if (out_valid) begin
            check("m_pc", out_pc, exp_pc);
            check("m_opcode", out_opcode, w[15:12]);
            check("m_rd", out_rd, w[11:9]);
            check("m_rs", out_rs, w[8:6]);
            check("m_imm", out_imm, w[7:0]);
            check("m_target", out_target, w[11:8]);
            if (out_ready) begin
                if (w[15:12] == 4'hC) begin
                    pending = 1;
                    br_tgt  = w[11:8];
                    br_next = exp_pc + 4'd1;
                end else begin
                    exp_pc = skip(w[15:12] == 4'h8 ? w[11:8] : exp_pc + 4'd1);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_issue(input logic [3:0] pc, input string name);
        bit found;
        found = 0;
        for (int i = 0; i < 64 && !found; i++) begin
            step(1);
            found = out_valid && out_pc == pc;
        end
        check(name, found, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    initial begin
        rom[0]  = 16'h1E07; rom[1]  = 16'h2240; rom[2]  = 16'h3240; rom[3]  = 16'hB101;
        rom[4]  = 16'hCA00; rom[5]  = 16'h2280; rom[6]  = 16'h8300; rom[7]  = 16'hE000;
        rom[8]  = 16'hE000; rom[9]  = 16'hE000; rom[10] = 16'h1000; rom[11] = 16'hE200;
        rom[12] = 16'hE200; rom[13] = 16'hE200; rom[14] = 16'hE200; rom[15] = 16'hF200;
        step(2);
        out_ready = 1;
        rst = 0;
        check("rst_valid", out_valid, 0);
        check("rst_addr", rom_addr, 0);
        check("rst_fields", {out_opcode, out_rd, out_rs, out_imm, out_target, out_pc}, 0);
        step(1);
        check("first_valid", out_valid, 1);
        check("first_op_rd_imm", {out_opcode, out_rd, out_imm}, {4'h1, 3'd7, 8'h07});
        check("first_pc", out_pc, 0);
        check("first_addr", rom_addr, 1);
        // branch taken; pulse during ISSUE must be ignored
        wait_issue(4, "reach_br1");
        br_resolve_valid = 1;
        br_taken = 1;
        step(1);
        br_resolve_valid = 0;
        check("br_stall_valid", out_valid, 0);
        step(2);
        check("br_ignored_addr", rom_addr, 5);
        br_resolve_valid = 1;
        step(1);
        br_resolve_valid = 0;
        check("br_taken_addr", rom_addr, 10);
        step(1);
        check("br_taken_pc", {out_valid, out_pc}, {1'b1, 4'd10});
        wait_issue(15, "reach_15");
        step(1);
        check("wrap_addr", rom_addr, 0);
        wait_issue(0, "wrap_issue");
        // branch not taken, then stall on ADD
        wait_issue(4, "reach_br2");
        step(1);
        br_resolve_valid = 1;
        br_taken = 0;
        step(1);
        br_resolve_valid = 0;
        check("br_nt_addr", rom_addr, 5);
        step(1);
        check("add_fields", {out_pc, out_opcode, out_rd, out_rs, out_imm}, {4'd5, 4'h2, 3'd1, 3'd2, 8'h80});
        out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            step(1);
            check("stall_hold", {out_valid, out_pc, out_opcode, out_imm, rom_addr}, {1'b1, 4'd5, 4'h2, 8'h80, 4'd6});
        end
        out_ready = 1;
        step(1);
`ifdef INSTR_FETCH_JMP_FOLD_EN
        step(1);
        check("fold_addr", {out_valid, rom_addr}, {1'b0, 4'd3});
        step(1);
        check("fold_next_pc", {out_valid, out_pc}, {1'b1, 4'd3});
`else
        step(1);
        check("jmp_issue", {out_valid, out_pc, out_opcode, out_target}, {1'b1, 4'd6, 4'h8, 4'd3});
        step(1);
        check("jmp_addr", rom_addr, 3);
        step(1);
        check("jmp_next_pc", {out_valid, out_pc}, {1'b1, 4'd3});
`endif
        // reset while waiting on a branch, then a stale resolve
        wait_issue(4, "reach_br3");
        step(1);
        rst = 1;
        step(1);
        rst = 0;
        br_resolve_valid = 1;
        br_taken = 1;
        check("midrst_state", {out_valid, rom_addr}, {1'b0, 4'd0});
        step(1);
        br_resolve_valid = 0;
        check("midrst_issue", {out_valid, out_pc, rom_addr}, {1'b1, 4'd0, 4'd1});
        step(2);
        check("midrst_next", {out_valid, out_pc}, {1'b1, 4'd1});
        step(2);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
